// File: rtl/dispatch_rename_ctrl_pkg.sv
// Shared types and constants for the dispatch/rename controller slice.
package dispatch_rename_ctrl_pkg;

    // Width of the tag field held in each register status entry.
    localparam int unsigned STATUS_TAG_W = 6;

    localparam int unsigned QIDX_INT  = 0;
    localparam int unsigned QIDX_LDST = 1;
    localparam int unsigned QIDX_MULT = 2;
    localparam int unsigned QIDX_DIV  = 3;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } dispatch_state_e;

    typedef struct packed {
        logic                    pending;
        logic [STATUS_TAG_W-1:0] tag;
    } status_entry_t;

endpackage

// File: rtl/dispatch_rename_ctrl_free_list.sv
// Circular free-tag FIFO, preloaded with tags 0..NUM_TAGS-1 while rst is high.
module tag_free_list #(
    parameter int unsigned NUM_TAGS = 64,
    parameter int unsigned TAG_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W:0]   count
);

    localparam int unsigned PTR_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(NUM_TAGS);

    logic [TAG_W-1:0] mem [NUM_TAGS];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_TAGS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                mem[i] <= TAG_W'(i);
            end
            rptr  <= '0;
            wptr  <= '0;
            count <= FULL_COUNT;
        end else begin
            if (push) begin
                mem[wptr] <= push_tag;
                wptr      <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + (TAG_W+1)'(1);
                2'b01:   count <= count - (TAG_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A push into a full list without a matching pop would overwrite a live tag.
    always_ff @(posedge clk) begin
        if (!rst && push && !pop) begin
            assert (count != FULL_COUNT);
        end
    end

endmodule

// File: rtl/dispatch_rename_ctrl.sv
// Dispatch/rename controller: tag allocation, register status, CDB wakeup,
// per-queue backpressure and branch-wait stall.
module dispatch_rename_ctrl
    import dispatch_rename_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned TAG_W         = STATUS_TAG_W,
    parameter int unsigned NUM_TAGS      = 64,
    parameter int unsigned NUM_QUEUES    = 4,
    parameter int unsigned AREG_W        = $clog2(NUM_ARCH_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifq_valid,
    input  logic [AREG_W-1:0]     dec_rs1,
    input  logic [AREG_W-1:0]     dec_rs2,
    input  logic [AREG_W-1:0]     dec_rd,
    input  logic                  dec_rd_we,
    input  logic [NUM_QUEUES-1:0] dec_queue_sel,
    input  logic                  dec_is_branch,
    input  logic                  dec_is_jump,
    input  logic [NUM_QUEUES-1:0] queue_full,
    input  logic                  cdb_valid,
    input  logic [TAG_W-1:0]      cdb_tag,
    input  logic                  cdb_branch,
    input  logic                  cdb_branch_taken,
    output logic                  ifq_ren,
    output logic [NUM_QUEUES-1:0] dispatch_en,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [TAG_W-1:0]      rs1_tag,
    output logic [TAG_W-1:0]      rs2_tag,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic                  rs1_bypass,
    output logic                  rs2_bypass,
    output logic                  regfile_we,
    output logic [AREG_W-1:0]     regfile_waddr,
    output logic                  redirect,
    output logic [TAG_W:0]        tags_free
);

    dispatch_state_e state;
    dispatch_state_e state_nxt;
    status_entry_t   status [NUM_ARCH_REGS];

    logic             alloc;
    logic             fire;
    logic             pop;
    logic [TAG_W-1:0] fl_head;
    logic [TAG_W:0]   fl_count;
    logic             cdb_hit;
    logic [AREG_W-1:0] cdb_reg;
    logic             redirect_c;
    status_entry_t    e1;
    status_entry_t    e2;
    logic             p1, p2, hit1, hit2;

    assign alloc = dec_rd_we & (dec_rd != '0);
    assign fire  = ~rst & ifq_valid & (state == RUN) & ~|(dec_queue_sel & queue_full)
                 & (~alloc | (fl_count != '0));
    assign pop   = fire & alloc;

    tag_free_list #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_free_list (
        .clk      (clk),
        .rst      (rst),
        .push     (~rst & cdb_valid),
        .push_tag (cdb_tag),
        .pop      (pop),
        .head     (fl_head),
        .count    (fl_count)
    );

    // Only one live mapping can hold a given tag, so the first match is the match.
    always_comb begin
        cdb_hit = 1'b0;
        cdb_reg = '0;
        for (int unsigned r = 1; r < NUM_ARCH_REGS; r++) begin
            if (!cdb_hit && status[r].pending && (TAG_W'(status[r].tag) == cdb_tag)) begin
                cdb_hit = 1'b1;
                cdb_reg = AREG_W'(r);
            end
        end
    end

    // Dispatch update takes priority so a same-cycle wakeup cannot erase the new mapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_ARCH_REGS; r++) begin
                status[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_ARCH_REGS; r++) begin
                if (pop && (dec_rd == AREG_W'(r))) begin
                    status[r] <= '{pending: 1'b1, tag: STATUS_TAG_W'(fl_head)};
                end else if (cdb_valid && status[r].pending
                             && (TAG_W'(status[r].tag) == cdb_tag)) begin
                    status[r].pending <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        redirect_c = 1'b0;
        case (state)
            RUN: begin
                if (fire && dec_is_branch) state_nxt = BR_WAIT;
                redirect_c = fire & dec_is_jump;
            end
            BR_WAIT: begin
                if (cdb_branch) begin
                    state_nxt  = RUN;
                    redirect_c = cdb_branch_taken;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        e1   = status[dec_rs1];
        e2   = status[dec_rs2];
        p1   = e1.pending & (dec_rs1 != '0);
        p2   = e2.pending & (dec_rs2 != '0);
        hit1 = p1 & cdb_valid & (TAG_W'(e1.tag) == cdb_tag);
        hit2 = p2 & cdb_valid & (TAG_W'(e2.tag) == cdb_tag);

        ifq_ren       = 1'b0;
        dispatch_en   = '0;
        rd_tag        = '0;
        rs1_tag       = '0;
        rs2_tag       = '0;
        rs1_pending   = 1'b0;
        rs2_pending   = 1'b0;
        rs1_bypass    = 1'b0;
        rs2_bypass    = 1'b0;
        regfile_we    = 1'b0;
        regfile_waddr = '0;
        redirect      = 1'b0;
        tags_free     = '0;
        if (!rst) begin
            ifq_ren       = fire;
            dispatch_en   = fire ? dec_queue_sel : '0;
            rd_tag        = fire ? fl_head : '0;
            rs1_tag       = TAG_W'(e1.tag);
            rs2_tag       = TAG_W'(e2.tag);
            rs1_pending   = p1 & ~hit1;
            rs2_pending   = p2 & ~hit2;
            rs1_bypass    = hit1;
            rs2_bypass    = hit2;
            regfile_we    = cdb_valid & cdb_hit;
            regfile_waddr = (cdb_valid & cdb_hit) ? cdb_reg : '0;
            redirect      = redirect_c;
            tags_free     = fl_count;
        end
    end

endmodule

// File: tb/tb_dispatch_rename_ctrl.sv
// Directed bench for dispatch_rename_ctrl with a queue/array reference model.
module tb_dispatch_rename_ctrl;

    logic       clk;
    logic       rst;
    logic       ifq_valid;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_rd_we;
    logic [3:0] dec_queue_sel;
    logic       dec_is_branch, dec_is_jump;
    logic [3:0] queue_full;
    logic       cdb_valid;
    logic [5:0] cdb_tag;
    logic       cdb_branch, cdb_branch_taken;
    logic       ifq_ren;
    logic [3:0] dispatch_en;
    logic [5:0] rd_tag, rs1_tag, rs2_tag;
    logic       rs1_pending, rs2_pending, rs1_bypass, rs2_bypass;
    logic       regfile_we;
    logic [4:0] regfile_waddr;
    logic       redirect;
    logic [6:0] tags_free;

    int n_vec = 0;
    int n_err = 0;

    dispatch_rename_ctrl #(
        .NUM_ARCH_REGS (32),
        .TAG_W         (6),
        .NUM_TAGS      (64),
        .NUM_QUEUES    (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ifq_valid        (ifq_valid),
        .dec_rs1          (dec_rs1),
        .dec_rs2          (dec_rs2),
        .dec_rd           (dec_rd),
        .dec_rd_we        (dec_rd_we),
        .dec_queue_sel    (dec_queue_sel),
        .dec_is_branch    (dec_is_branch),
        .dec_is_jump      (dec_is_jump),
        .queue_full       (queue_full),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_branch       (cdb_branch),
        .cdb_branch_taken (cdb_branch_taken),
        .ifq_ren          (ifq_ren),
        .dispatch_en      (dispatch_en),
        .rd_tag           (rd_tag),
        .rs1_tag          (rs1_tag),
        .rs2_tag          (rs2_tag),
        .rs1_pending      (rs1_pending),
        .rs2_pending      (rs2_pending),
        .rs1_bypass       (rs1_bypass),
        .rs2_bypass       (rs2_bypass),
        .regfile_we       (regfile_we),
        .regfile_waddr    (regfile_waddr),
        .redirect         (redirect),
        .tags_free        (tags_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rename map as plain arrays, free list as a queue.
    bit         m_pend [32];
    logic [5:0] m_tag  [32];
    logic [5:0] fl [$];
    bit         m_wait;

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_pend[r] = 1'b0;
            m_tag[r]  = '0;
        end
        fl.delete();
        for (int i = 0; i < 64; i++) fl.push_back(6'(i));
        m_wait = 1'b0;
    endtask

    initial begin
        bit         e_alloc, e_fire, p1, p2, h1, h2, found;
        logic [4:0] e_waddr;
        logic [5:0] popped;
        model_reset();
        forever begin
            @(negedge clk);
            e_alloc = dec_rd_we && (dec_rd != 0);
            e_fire  = !rst && ifq_valid && !m_wait && ((dec_queue_sel & queue_full) == 0)
                      && (!e_alloc || fl.size() != 0);
            p1 = (dec_rs1 != 0) && m_pend[dec_rs1];
            p2 = (dec_rs2 != 0) && m_pend[dec_rs2];
            h1 = p1 && cdb_valid && (cdb_tag == m_tag[dec_rs1]);
            h2 = p2 && cdb_valid && (cdb_tag == m_tag[dec_rs2]);
            found = 1'b0;
            e_waddr = '0;
            for (int r = 1; r < 32; r++) begin
                if (!found && m_pend[r] && m_tag[r] == cdb_tag) begin
                    found = 1'b1;
                    e_waddr = 5'(r);
                end
            end
            if (rst) begin
                chk("m_ifq_ren", ifq_ren, 0);
                chk("m_dispatch_en", dispatch_en, 0);
                chk("m_rd_tag", rd_tag, 0);
                chk("m_rs1_tag", rs1_tag, 0);
                chk("m_rs2_tag", rs2_tag, 0);
                chk("m_rs_flags", {rs1_pending, rs2_pending, rs1_bypass, rs2_bypass}, 0);
                chk("m_regfile", {regfile_we, regfile_waddr}, 0);
                chk("m_redirect", redirect, 0);
                chk("m_tags_free", tags_free, 0);
            end else begin
                chk("m_ifq_ren", ifq_ren, e_fire);
                chk("m_dispatch_en", dispatch_en, e_fire ? dec_queue_sel : 4'd0);
                if (!e_fire) chk("m_rd_tag", rd_tag, 0);
                else if (fl.size() != 0) chk("m_rd_tag", rd_tag, fl[0]);
                chk("m_rs1_tag", rs1_tag, m_tag[dec_rs1]);
                chk("m_rs2_tag", rs2_tag, m_tag[dec_rs2]);
                chk("m_rs1_pending", rs1_pending, p1 && !h1);
                chk("m_rs2_pending", rs2_pending, p2 && !h2);
                chk("m_rs1_bypass", rs1_bypass, h1);
                chk("m_rs2_bypass", rs2_bypass, h2);
                chk("m_regfile_we", regfile_we, cdb_valid && found);
                chk("m_regfile_waddr", regfile_waddr, (cdb_valid && found) ? e_waddr : 5'd0);
                chk("m_redirect", redirect,
                    (!m_wait && e_fire && dec_is_jump) || (m_wait && cdb_branch && cdb_branch_taken));
                chk("m_tags_free", tags_free, fl.size());
            end
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                popped = '0;
                if (e_fire && e_alloc) popped = fl.pop_front();
                if (cdb_valid) begin
                    fl.push_back(cdb_tag);
                    for (int r = 0; r < 32; r++)
                        if (m_pend[r] && m_tag[r] == cdb_tag) m_pend[r] = 1'b0;
                end
                if (e_fire && e_alloc) begin
                    m_pend[dec_rd] = 1'b1;
                    m_tag[dec_rd]  = popped;
                end
                if (!m_wait && e_fire && dec_is_branch) m_wait = 1'b1;
                else if (m_wait && cdb_branch)          m_wait = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifq_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_rd_we = 0;
        dec_queue_sel = 0; dec_is_branch = 0; dec_is_jump = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_branch = 0; cdb_branch_taken = 0;
    endtask

    task automatic instr(input logic [4:0] rd, input logic we, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [3:0] q, input logic br,
                         input logic jmp);
        ifq_valid = 1; dec_rd = rd; dec_rd_we = we; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_queue_sel = q; dec_is_branch = br; dec_is_jump = jmp;
    endtask

    initial begin
        rst = 1; queue_full = 0; idle();
        instr(5, 1, 0, 0, 4'b0001, 0, 0);
        cyc(); #3;
        chk("rst_ifq_ren", ifq_ren, 0);
        chk("rst_tags_free", tags_free, 0);

        cyc(); rst = 0; instr(5, 1, 1, 2, 4'b0001, 0, 0); #3;
        chk("add_rd_tag", rd_tag, 0);
        chk("add_dispatch_en", dispatch_en, 4'b0001);
        chk("add_ifq_ren", ifq_ren, 1);
        chk("add_tags_free_before", tags_free, 64);

        cyc(); idle(); dec_rs1 = 5; #3;
        chk("x5_pending", rs1_pending, 1);
        chk("x5_tag", rs1_tag, 0);
        chk("tags_free_63", tags_free, 63);

        cyc(); instr(6, 1, 5, 5, 4'b0001, 0, 0); cdb_valid = 1; cdb_tag = 0; #3;
        chk("sub_rs1_bypass", rs1_bypass, 1);
        chk("sub_rs2_bypass", rs2_bypass, 1);
        chk("sub_pending", {rs1_pending, rs2_pending}, 0);
        chk("sub_regfile_we", regfile_we, 1);
        chk("sub_regfile_waddr", regfile_waddr, 5);
        chk("sub_rd_tag", rd_tag, 1);

        cyc(); idle(); dec_rs1 = 5; dec_rs2 = 6; #3;
        chk("pushpop_tags_free", tags_free, 63);
        chk("x5_cleared", rs1_pending, 0);
        chk("x6_pending", rs2_pending, 1);
        chk("x6_tag", rs2_tag, 1);

        for (int i = 0; i < 63; i++) begin
            cyc(); instr(5'((i % 31) + 1), 1, 0, 0, 4'b0001, 0, 0);
        end
        cyc(); instr(7, 1, 0, 0, 4'b0001, 0, 0); #3;
        chk("empty_tags_free", tags_free, 0);
        chk("empty_stall", ifq_ren, 0);

        cyc(); instr(0, 0, 7, 8, 4'b0010, 0, 0); #3;
        chk("store_fires", ifq_ren, 1);
        chk("store_dispatch_en", dispatch_en, 4'b0010);

        cyc(); instr(7, 1, 0, 0, 4'b0001, 0, 0); cdb_valid = 1; cdb_tag = 1; #3;
        chk("return_same_cycle_stall", ifq_ren, 0);
        chk("stale_tag_no_we", regfile_we, 0);

        cyc(); cdb_valid = 0; #3;
        chk("after_free_fire", ifq_ren, 1);
        chk("after_free_rd_tag", rd_tag, 1);
        chk("after_free_count", tags_free, 1);

        cyc(); idle(); queue_full = 4'b0010; instr(0, 0, 0, 0, 4'b0010, 0, 0); #3;
        chk("ldst_full_stall", ifq_ren, 0);
        chk("ldst_full_en", dispatch_en, 0);

        cyc(); instr(0, 0, 0, 0, 4'b0001, 0, 0); #3;
        chk("int_not_full_fire", dispatch_en, 4'b0001);

        cyc(); idle(); queue_full = 0;
        for (int t = 2; t < 12; t++) begin
            cdb_valid = 1; cdb_tag = 6'(t);
            cyc();
        end
        idle(); #3;
        chk("freed_ten", tags_free, 10);

        instr(0, 0, 1, 2, 4'b0001, 1, 0); #3;
        chk("branch_fires", ifq_ren, 1);
        cyc(); instr(8, 1, 0, 0, 4'b0001, 0, 0); #3;
        chk("br_wait_hold", ifq_ren, 0);
        cyc(); cdb_branch = 1; cdb_branch_taken = 1; #3;
        chk("taken_redirect", redirect, 1);
        chk("taken_hold", ifq_ren, 0);
        cyc(); cdb_branch = 0; cdb_branch_taken = 0; #3;
        chk("redirect_one_cycle", redirect, 0);
        chk("resume_fire", ifq_ren, 1);
        chk("resume_rd_tag", rd_tag, 2);

        cyc(); instr(0, 0, 0, 0, 4'b0001, 1, 0);
        cyc(); idle(); cdb_branch = 1; cdb_branch_taken = 0; #3;
        chk("not_taken_redirect", redirect, 0);
        cyc(); cdb_branch = 0; instr(1, 1, 0, 0, 4'b0001, 0, 1); #3;
        chk("jump_redirect", redirect, 1);
        chk("jump_fires", ifq_ren, 1);
        cyc(); idle(); #3;
        chk("jump_redirect_off", redirect, 0);

        cyc(); rst = 1;
        cyc(); rst = 0;
        for (int k = 1; k <= 10; k++) begin
            instr(5'(k), 1, 0, 0, 4'b0001, 0, 0);
            cyc();
        end
        instr(0, 0, 0, 0, 4'b0001, 1, 0);
        cyc(); idle(); dec_rs1 = 3; #3;
        chk("ten_alloc_count", tags_free, 54);
        chk("x3_pending", rs1_pending, 1);
        rst = 1; cdb_branch = 1; cdb_branch_taken = 1; #1;
        chk("rst_no_redirect", redirect, 0);
        cyc(); rst = 0; cdb_branch = 0; cdb_branch_taken = 0;
        instr(9, 1, 3, 4, 4'b0001, 0, 0); #3;
        chk("post_rst_count", tags_free, 64);
        chk("post_rst_x3", rs1_pending, 0);
        chk("post_rst_run", ifq_ren, 1);
        chk("post_rst_rd_tag", rd_tag, 0);

        cyc(); idle();
        cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dispatch_rename_ctrl.md
Name: dispatch_rename_ctrl

Overview:
- Parametrised next-generation dispatch/rename controller for the out-of-order core.
- Sits between the IFQ/decoder and the issue queues.
- Renames destination registers with a circular free-tag list and a register status table, and forwards CDB tags to operands in the same cycle.
- Applies per-queue backpressure, and stalls dispatch behind an unresolved branch using a two-state FSM.
- The external register file is written through regfile_we/regfile_waddr.

Parameters:
NUM_ARCH_REGS, 32, architectural registers (x0 is never renamed)
TAG_W, 6, physical tag width
NUM_TAGS, 64, tags in the free list (must be ≤ 2**TAG_W)
NUM_QUEUES, 4, issue queues (int, ld/st, mult, div)
AREG_W, $clog2(NUM_ARCH_REGS), architectural register index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ifq_valid  in  1  decoded instruction present
dec_rs1  in  AREG_W  source register 1
dec_rs2  in  AREG_W  source register 2
dec_rd  in  AREG_W  destination register
dec_rd_we  in  1  instruction writes rd
dec_queue_sel  in  NUM_QUEUES  one-hot target queue
dec_is_branch  in  1  conditional branch
dec_is_jump  in  1  JAL/JALR
queue_full  in  NUM_QUEUES  per-queue full flags
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB tag
cdb_branch  in  1  CDB carries a branch resolution
cdb_branch_taken  in  1  resolved branch outcome
ifq_ren  out  1  pop IFQ (equals fire)
dispatch_en  out  NUM_QUEUES  one-hot queue write enable
rd_tag  out  TAG_W  allocated tag
rs1_tag, rs2_tag  out  TAG_W  producer tag of each source
rs1_pending, rs2_pending  out  1  source not yet available
rs1_bypass, rs2_bypass  out  1  take the operand from cdb_data this cycle
regfile_we  out  1  commit the CDB result to the register file
regfile_waddr  out  AREG_W  register to write
redirect  out  1  one-cycle fetch redirect/flush
tags_free  out  TAG_W+1  free-list occupancy

Behaviour:
- Reset, and every cycle rst is high:
  - all status entries not pending;
  - free list holds tags 0..NUM_TAGS-1 in order; read and write pointers 0; tags_free = NUM_TAGS;
  - FSM = RUN;
  - all outputs forced to 0.
- alloc = dec_rd_we & (dec_rd != 0).
- fire = ~rst & ifq_valid & (state == RUN) & ~|(dec_queue_sel & queue_full) & (~alloc | tags_free != 0).
  - A tag returning on the CDB is not usable by a dispatch in the same cycle.
- Outputs while fire is high (all combinational, zero latency):
  - ifq_ren = 1;
  - dispatch_en = dec_queue_sel (all zeros when fire is low);
  - rd_tag = free-list head.
- Registered effects of a fire with alloc:
  - free-list pop;
  - status[dec_rd] becomes {pending=1, tag=head} next cycle.
- Operand lookup is combinational on the current status entry, read before that instruction's own rd update (rs == rd reads the old mapping).
  - If the entry is pending, cdb_valid is high, and cdb_tag matches: bypass = 1 and pending = 0.
  - x0 is never pending.
- CDB handling, on cdb_valid:
  - the tag is pushed to the free list;
  - every status entry that is pending with tag == cdb_tag clears next cycle;
  - regfile_we = 1 combinationally, with regfile_waddr = the matching register.
  - If the mapping was already overwritten (no entry matches): tag freed, regfile_we = 0.
- Simultaneous push and pop: count unchanged; pointers wrap modulo NUM_TAGS.
- Same-register conflict: a dispatch writing rd and a CDB clearing the same rd in one cycle resolve to the new pending mapping (dispatch wins).
- Free-list overflow (push at NUM_TAGS) is illegal; covered by an assertion.
- FSM:
  - RUN → BR_WAIT when fire & dec_is_branch.
  - BR_WAIT: no dispatch. On cdb_branch → RUN, with redirect = cdb_branch_taken in that same cycle.
  - A jump that fires asserts redirect in its fire cycle; state stays RUN.
  - No speculative rename state exists, so no rollback is needed.
- Reset in BR_WAIT returns to RUN with no redirect.

Decomposition:
- Shared package: dispatch_state_e {RUN, BR_WAIT}; a status-entry struct {pending, tag}; the queue index constants QIDX_INT/LDST/MULT/DIV.
- Sub-module tag_free_list: parametrised circular FIFO (NUM_TAGS, TAG_W) preloaded at reset, with push, pop, head and count.

Test Plan:
- Reset, then dispatch `add x5` to int → rd_tag = 0, dispatch_en = 4'b0001, tags_free = 63; next cycle rs1 = x5 gives pending = 1, tag = 0.
- cdb_valid with tag 0 while dispatching `sub x6,x5,x5` → rs1_bypass = rs2_bypass = 1, pending = 0, regfile_we = 1, waddr = 5, tags_free unchanged.
- Exhaust all 64 tags → 65th allocating instruction stalls (ifq_ren = 0); a store (no rd) still dispatches; after one cdb_valid the stalled instruction fires on the next cycle.
- queue_full = 4'b0010 with a ld/st instruction → no fire; int instruction next → fires.
- Branch fires → BR_WAIT, next ifq instruction held; cdb_branch with taken = 1 → redirect pulse for 1 cycle, state RUN. Repeat with not-taken → redirect = 0.
- rst asserted in BR_WAIT with 10 tags allocated → next cycle tags_free = 64, all pending = 0, state RUN.
